pong_scene_gen: RTL and testbench
=================================

// Module: pong_scene_gen
// PURPOSE
//  Pixel source for the game; sits directly upstream of the 640x480@60Hz VGA controller.
//  Consumes its hcount/vcount and returns the 12-bit RGB pixel (rgb -> controller rgb_in).
//  Owns the game state: a player paddle, a ball and a miss counter.
//  Positions update once per frame, during vertical blanking.
// PARAMETERS
//  HLINES        640  visible columns
//  VLINES        480  visible lines
//  BALL_SIZE     8    ball edge length, pixels
//  PADDLE_X      16   paddle left column
//  PADDLE_W      8    paddle width
//  PADDLE_H      64   paddle height
//  BALL_SPEED    2    ball step per frame, each axis
//  PADDLE_SPEED  4    paddle step per frame
//  SERVE_FRAMES  60   frames held in SERVE before auto-launch
// PORTS
//  clk         in   1   system clock (counters from controller advance every 2nd clk)
//  rst         in   1   synchronous, active-high reset
//  hcount      in   11  horizontal pixel counter from VGA controller
//  vcount      in   11  vertical pixel counter from VGA controller
//  btn_up      in   1   async push button, paddle up
//  btn_down    in   1   async push button, paddle down
//  btn_serve   in   1   async push button, early serve
//  rgb         out  12  pixel colour R[11:8] G[7:4] B[3:0]
//  miss_count  out  4   missed balls, saturating
//  frame_tick  out  1   one-clk pulse at start of vertical blank
// BEHAVIOUR
//  Reset: rgb=0, frame_tick=0, miss_count=0, state=SERVE, serve_cnt=0.
//    Reset also places the paddle at py=(VLINES-PADDLE_H)/2=208.
//    Reset places the ball at (HLINES/2-BALL_SIZE/2, VLINES/2-BALL_SIZE/2)=(316,236), moving right/down.
//  Buttons: 2-FF synchroniser each; sampled only on frame_tick.
//  frame_tick: rising edge of the registered compare (vcount==VLINES && hcount==0).
//    Exactly one clk per frame, even though the counters hold for 2 clk.
//  Paddle (every state, on frame_tick):
//    up only: py-=PADDLE_SPEED, floor 0.
//    down only: py+=PADDLE_SPEED, ceiling VLINES-PADDLE_H.
//    both or neither: hold.
//  FSM states SERVE, PLAY, MISS; all transitions occur on frame_tick only.
//    SERVE: ball parked at centre, dir right/down; serve_cnt++.
//      -> PLAY when serve_cnt==SERVE_FRAMES-1 or btn_serve=1; serve_cnt cleared on exit.
//    PLAY: ball steps BALL_SPEED per axis, with collisions below.
//      Ball update uses the paddle position from before this frame's paddle move.
//    MISS: lasts exactly one frame, ball hidden, then -> SERVE.
//      miss_count+1 on entry, saturates at 15.
//  Collisions in PLAY (evaluated on next position; x and y are independent):
//    top: by<BALL_SPEED while moving up -> by=0, dy=down.
//    bottom: by+BALL_SIZE+BALL_SPEED>VLINES -> by=VLINES-BALL_SIZE, dy=up.
//    right: bx+BALL_SIZE+BALL_SPEED>HLINES -> bx=HLINES-BALL_SIZE, dx=left.
//    left: moving left and bx-BALL_SPEED<PADDLE_X+PADDLE_W:
//      overlap (by+BALL_SIZE>py && by<py+PADDLE_H) -> bx=PADDLE_X+PADDLE_W, dx=right.
//      otherwise -> MISS.
//    Corner: top/bottom and right both hit -> both axes reflect in the same frame.
//  Pixel path: rgb is registered, 1 clk after hcount/vcount.
//    Outside visible area (hcount>=HLINES or vcount>=VLINES): rgb=0.
//    Priority: ball 12'hFFF > paddle 12'h0F0 > score bar > background.
//    Background is 12'h008, or 12'hF00 while in MISS.
//  Arithmetic: 11-bit unsigned coordinates; comparisons are done as sums, never subtraction below 0.
//  rst mid-frame: all state returns to reset values on the next clk; no partial update is kept.
// CONFIGURATION
//  SCORE_BAR_EN defined: yellow 12'hFF0 bar on rows 0..3, columns 0..16*miss_count-1.
//    The bar sits below ball/paddle priority.
//  SCORE_BAR_EN undefined: no bar drawn; the miss_count port and its counting are unchanged.
// STRUCTURE
//  pong_pkg: state enum (SERVE/PLAY/MISS), colour localparams, coord_t=logic[10:0].
//  Sub-module pong_ball_ctrl: ball position/direction registers and collision logic.
//    Inputs: frame_tick, state, py. Outputs: bx, by, miss_evt.
//  Top level: FSM, paddle, synchronisers, pixel mux.
// TESTING
//  1 reset, hcount=316,vcount=236 -> rgb=FFF next clk; hcount=20,vcount=210 -> 0F0.
//    hcount=700 -> rgb=000.
//  2 btn_up held 60 frames -> py stops at 0; btn_up+btn_down together -> py unchanged.
//  3 no buttons -> PLAY after 60 frame_ticks; with btn_serve -> PLAY after 1 tick.
//  4 ball forced to by=1 moving up -> next tick by=0, dy=down.
//    ball at bx=HLINES-BALL_SIZE-1 moving right -> bx=632, dx=left.
//  5 ball at bx=25 moving left, py covers by -> bx=24, dx=right, miss_count unchanged.
//  6 paddle away from ball -> MISS for 1 frame, background F00, miss_count=1.
//    After 16 misses miss_count=15.
//    SCORE_BAR_EN: pixel(5,2) = FF0 once miss_count>=1.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types, playfield geometry and colours for the pong scene generator.
// Exports coord_t, state_t and the in_span() window helper.
package pong_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    MISS
  } state_t;

  localparam coord_t HLINES       = 11'd640;
  localparam coord_t VLINES       = 11'd480;
  localparam coord_t BALL_SIZE    = 11'd8;
  localparam coord_t PADDLE_X     = 11'd16;
  localparam coord_t PADDLE_W     = 11'd8;
  localparam coord_t PADDLE_H     = 11'd64;
  localparam coord_t BALL_SPEED   = 11'd2;
  localparam coord_t PADDLE_SPEED = 11'd4;
  localparam int     SERVE_FRAMES = 60;

  localparam coord_t BALL_X0 = HLINES / 2 - BALL_SIZE / 2;
  localparam coord_t BALL_Y0 = VLINES / 2 - BALL_SIZE / 2;
  localparam coord_t PY0     = (VLINES - PADDLE_H) / 2;
  localparam coord_t PY_MAX  = VLINES - PADDLE_H;

  localparam logic [11:0] C_BALL   = 12'hFFF;
  localparam logic [11:0] C_PADDLE = 12'h0F0;
  localparam logic [11:0] C_BAR    = 12'hFF0;
  localparam logic [11:0] C_BG     = 12'h008;
  localparam logic [11:0] C_MISS   = 12'hF00;
  localparam logic [11:0] C_BLACK  = 12'h000;

  // p lies in [lo, lo+len); upper bound formed as a sum.
  function automatic logic in_span(coord_t p, coord_t lo, coord_t len);
    return (p >= lo) && (p < lo + len);
  endfunction

endpackage

// File: rtl/pong_scene_gen_if.sv
// Pixel bus between the VGA controller and the scene generator.
// master: drives hcount/vcount, takes rgb. slave: the reverse.
interface pong_scene_gen_if;
  import pong_pkg::*;

  coord_t      hcount;
  coord_t      vcount;
  logic [11:0] rgb;

  modport master (output hcount, output vcount, input rgb);
  modport slave  (input hcount, input vcount, output rgb);
endinterface

// File: rtl/pong_ball_ctrl.sv
// Ball position/direction registers and wall/paddle collision logic.
// In: clk, rst, frame_tick, state, py. Out: bx, by, miss_evt (comb, PLAY tick).
module pong_ball_ctrl
  import pong_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   frame_tick,
  input  state_t state,
  input  coord_t py,
  output coord_t bx,
  output coord_t by,
  output logic   miss_evt
);

  coord_t bx_q, bx_d, by_q, by_d;
  logic   dx_q, dx_d;  // 1: moving left
  logic   dy_q, dy_d;  // 1: moving up
  logic   overlap;

  assign overlap = (by_q + BALL_SIZE > py) && (by_q < py + PADDLE_H);

  always_comb begin
    bx_d     = bx_q;
    by_d     = by_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    miss_evt = 1'b0;
    if (frame_tick) begin
      unique case (state)
        PLAY: begin
          if (!dx_q) begin
            if (bx_q + BALL_SIZE + BALL_SPEED > HLINES) begin
              bx_d = HLINES - BALL_SIZE;
              dx_d = 1'b1;
            end else begin
              bx_d = bx_q + BALL_SPEED;
            end
          end else if (bx_q < PADDLE_X + PADDLE_W + BALL_SPEED) begin
            if (overlap) begin
              bx_d = PADDLE_X + PADDLE_W;
              dx_d = 1'b0;
            end else begin
              miss_evt = 1'b1;
            end
          end else begin
            bx_d = bx_q - BALL_SPEED;
          end
          if (dy_q) begin
            if (by_q < BALL_SPEED) begin
              by_d = '0;
              dy_d = 1'b0;
            end else begin
              by_d = by_q - BALL_SPEED;
            end
          end else if (by_q + BALL_SIZE + BALL_SPEED > VLINES) begin
            by_d = VLINES - BALL_SIZE;
            dy_d = 1'b1;
          end else begin
            by_d = by_q + BALL_SPEED;
          end
          // A missed ball freezes where it was; it is hidden then re-parked.
          if (miss_evt) begin
            bx_d = bx_q;
            by_d = by_q;
            dx_d = dx_q;
            dy_d = dy_q;
          end
        end
        SERVE, MISS: begin
          bx_d = BALL_X0;
          by_d = BALL_Y0;
          dx_d = 1'b0;
          dy_d = 1'b0;
        end
        default: begin
          bx_d = BALL_X0;
          by_d = BALL_Y0;
          dx_d = 1'b0;
          dy_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bx_q <= BALL_X0;
      by_q <= BALL_Y0;
      dx_q <= 1'b0;
      dy_q <= 1'b0;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign bx = bx_q;
  assign by = by_q;

endmodule

// File: rtl/pong_scene_gen.sv
// Pong pixel source: game FSM, paddle, button syncs, registered pixel mux.
// Ports: clk, rst, vga (slave: hcount/vcount in, rgb out), btn_up/down/serve,
// miss_count, frame_tick. SCORE_BAR_EN adds the yellow miss bar.
module pong_scene_gen
  import pong_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pong_scene_gen_if.slave   vga,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_serve,
  output logic [3:0]        miss_count,
  output logic              frame_tick
);

  logic [1:0]  up_s_q, dn_s_q, sv_s_q;
  logic        cmp_d, cmp_q, tick_q;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  mc_q, mc_d;
  coord_t      py_q, py_d;
  logic [11:0] rgb_q, rgb_d;
  coord_t      bx, by;
  logic        miss_evt;
  logic        up, dn, sv;
  logic        vis, ball_on, pad_on, bar_on;

  assign up    = up_s_q[1];
  assign dn    = dn_s_q[1];
  assign sv    = sv_s_q[1];
  // Counters hold for 2 clk; the edge detect keeps the tick to one clk.
  assign cmp_d = (vga.vcount == VLINES) && (vga.hcount == '0);

  pong_ball_ctrl u_ball (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (tick_q),
    .state      (state_q),
    .py         (py_q),
    .bx         (bx),
    .by         (by),
    .miss_evt   (miss_evt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_d    = mc_q;
    py_d    = py_q;
    if (tick_q) begin
      if (up && !dn) begin
        py_d = (py_q < PADDLE_SPEED) ? '0 : py_q - PADDLE_SPEED;
      end else if (dn && !up) begin
        py_d = (py_q + PADDLE_SPEED > PY_MAX) ? PY_MAX : py_q + PADDLE_SPEED;
      end
      unique case (state_q)
        SERVE: begin
          if (cnt_q == 6'(SERVE_FRAMES - 1) || sv) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        PLAY: begin
          if (miss_evt) begin
            state_d = MISS;
            mc_d    = (mc_q == 4'd15) ? mc_q : mc_q + 4'd1;
          end
        end
        MISS:    state_d = SERVE;
        default: state_d = SERVE;
      endcase
    end
  end

  always_comb begin
    vis     = (vga.hcount < HLINES) && (vga.vcount < VLINES);
    ball_on = (state_q != MISS) &&
              in_span(vga.hcount, bx, BALL_SIZE) &&
              in_span(vga.vcount, by, BALL_SIZE);
    pad_on  = in_span(vga.hcount, PADDLE_X, PADDLE_W) &&
              in_span(vga.vcount, py_q, PADDLE_H);
`ifdef SCORE_BAR_EN
    bar_on  = (vga.vcount < 11'd4) &&
              (vga.hcount < {3'b000, mc_q, 4'b0000});
`else
    bar_on  = 1'b0;
`endif
    rgb_d = (state_q == MISS) ? C_MISS : C_BG;
    if (!vis)         rgb_d = C_BLACK;
    else if (ball_on) rgb_d = C_BALL;
    else if (pad_on)  rgb_d = C_PADDLE;
    else if (bar_on)  rgb_d = C_BAR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_s_q  <= '0;
      dn_s_q  <= '0;
      sv_s_q  <= '0;
      cmp_q   <= 1'b0;
      tick_q  <= 1'b0;
      state_q <= SERVE;
      cnt_q   <= '0;
      mc_q    <= '0;
      py_q    <= PY0;
      rgb_q   <= C_BLACK;
    end else begin
      up_s_q  <= {up_s_q[0], btn_up};
      dn_s_q  <= {dn_s_q[0], btn_down};
      sv_s_q  <= {sv_s_q[0], btn_serve};
      cmp_q   <= cmp_d;
      tick_q  <= cmp_d & ~cmp_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_q    <= mc_d;
      py_q    <= py_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga.rgb    = rgb_q;
  assign miss_count = mc_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_pong_scene_gen.sv
// Directed bench for pong_scene_gen: reset, pixels, paddle, serve, bounces,
// paddle hit, miss and miss_count saturation; frames driven as short ticks.
module tb_pong_scene_gen;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_serve;
  logic [3:0] miss_count;
  logic       frame_tick;
  int         tests = 0;
  int         fails = 0;
  int         n = 0;
  int         misses = 0;

  always #5 clk = ~clk;

  pong_scene_gen_if vif ();

  pong_scene_gen dut (
    .clk        (clk),
    .rst        (rst),
    .vga        (vif),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_serve  (btn_serve),
    .miss_count (miss_count),
    .frame_tick (frame_tick)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // One frame: counters sit on (0, VLINES) for 2 clk, then move to blanking.
  task automatic frame();
    int ticks;
    ticks = 0;
    @(negedge clk);
    vif.hcount = 11'd0;
    vif.vcount = VLINES;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (frame_tick) ticks++;
    end
    @(negedge clk);
    vif.hcount = 11'd700;
    vif.vcount = 11'd0;
    @(posedge clk);
    #1;
    if (frame_tick) ticks++;
    chk("tick_once", 32'(ticks), 32'd1);
  endtask

  task automatic play(int upto);
    while (n < upto) begin
      frame();
      n++;
    end
  endtask

  task automatic pix(string tag, int h, int v, logic [11:0] exp);
    @(negedge clk);
    vif.hcount = 11'(h);
    vif.vcount = 11'(v);
    @(posedge clk);
    #1;
    chk(tag, 32'(vif.rgb), 32'(exp));
  endtask

  task automatic pos(string tag, int x, int y);
    chk({tag, "_bx"}, 32'(dut.bx), 32'(x));
    chk({tag, "_by"}, 32'(dut.by), 32'(y));
  endtask

  initial begin
    rst       = 1'b1;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_serve = 1'b0;
    vif.hcount = 11'd700;
    vif.vcount = 11'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(vif.rgb), 32'h000);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(SERVE));
    chk("rst_py", 32'(dut.py_q), 32'd208);
    pos("rst", 316, 236);
    @(negedge clk);
    rst = 1'b0;

    pix("ball_tl", 316, 236, 12'hFFF);
    pix("ball_br", 323, 243, 12'hFFF);
    pix("ball_right", 324, 236, 12'h008);
    pix("paddle", 20, 210, 12'h0F0);
    pix("paddle_below", 20, 272, 12'h008);
    pix("hblank", 700, 236, 12'h000);
    pix("vblank", 316, 480, 12'h000);
    pix("bg", 300, 100, 12'h008);
    pix("bar0", 5, 2, 12'h008);

    // Paddle floor while serving; auto-launch on the 60th tick.
    btn_up = 1'b1;
    settle();
    repeat (52) frame();
    chk("py_floor", 32'(dut.py_q), 32'd0);
    repeat (7) frame();
    chk("py_hold0", 32'(dut.py_q), 32'd0);
    chk("serve_59", 32'(dut.state_q), 32'(SERVE));
    btn_up = 1'b0;
    settle();
    frame();
    chk("play_60", 32'(dut.state_q), 32'(PLAY));

    // Round 1: both buttons hold the paddle, ball bounces, then a miss.
    btn_up   = 1'b1;
    btn_down = 1'b1;
    settle();
    play(5);
    chk("py_both", 32'(dut.py_q), 32'd0);
    pos("n5", 326, 246);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    settle();
    play(118); pos("n118", 552, 472);
    play(119); chk("n119_by", 32'(dut.by), 32'd472);
    play(120); chk("n120_by", 32'(dut.by), 32'd470);
    play(158); chk("n158_bx", 32'(dut.bx), 32'd632);
    play(159); chk("n159_bx", 32'(dut.bx), 32'd632);
    play(160); chk("n160_bx", 32'(dut.bx), 32'd630);
    play(355); chk("n355_by", 32'(dut.by), 32'd0);
    play(356); chk("n356_by", 32'(dut.by), 32'd0);
    play(357); chk("n357_by", 32'(dut.by), 32'd2);
    play(463);
    pos("n463", 24, 214);
    chk("n463_state", 32'(dut.state_q), 32'(PLAY));
    play(464);
    chk("miss_state", 32'(dut.state_q), 32'(MISS));
    chk("miss_cnt1", 32'(miss_count), 32'd1);
    pix("miss_bg", 300, 100, 12'hF00);
    pix("miss_hidden", 26, 216, 12'hF00);
    pix("miss_paddle", 20, 10, 12'h0F0);
    frame();
    chk("miss_to_serve", 32'(dut.state_q), 32'(SERVE));
    pos("reparked", 316, 236);
    chk("miss_cnt_keep", 32'(miss_count), 32'd1);
`ifdef SCORE_BAR_EN
    pix("bar1", 5, 2, 12'hFF0);
    pix("bar1_end", 16, 2, 12'h008);
`else
    pix("bar1", 5, 2, 12'h008);
`endif

    // Round 2: early serve, paddle parked at 200 returns the ball.
    btn_serve = 1'b1;
    settle();
    frame();
    chk("early_serve", 32'(dut.state_q), 32'(PLAY));
    btn_serve = 1'b0;
    btn_down  = 1'b1;
    n = 0;
    settle();
    play(50);
    btn_down = 1'b0;
    settle();
    chk("py_200", 32'(dut.py_q), 32'd200);
    play(463); pos("r2_n463", 24, 214);
    play(464);
    pos("hit", 24, 216);
    chk("hit_state", 32'(dut.state_q), 32'(PLAY));
    chk("hit_miss_cnt", 32'(miss_count), 32'd1);
    play(465); chk("hit_right", 32'(dut.bx), 32'd26);

    // Paddle out of the way, serve held: run up to 16 misses in total.
    btn_up    = 1'b1;
    btn_serve = 1'b1;
    settle();
    misses = 1;
    for (int f = 0; f < 20000 && misses < 16; f++) begin
      frame();
      if (dut.state_q == MISS) begin
        misses++;
        chk("miss_sat", 32'(miss_count), 32'(misses > 15 ? 15 : misses));
      end
    end
    chk("miss_rounds", 32'(misses), 32'd16);
    frame();
    chk("sat_final", 32'(miss_count), 32'd15);
    chk("sat_serve", 32'(dut.state_q), 32'(SERVE));

    // Reset mid-frame.
    btn_up    = 1'b0;
    btn_serve = 1'b0;
    @(negedge clk);
    vif.hcount = 11'd316;
    vif.vcount = 11'd236;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_rgb", 32'(vif.rgb), 32'h000);
    chk("mid_rst_miss", 32'(miss_count), 32'd0);
    chk("mid_rst_py", 32'(dut.py_q), 32'd208);
    chk("mid_rst_state", 32'(dut.state_q), 32'(SERVE));
    @(negedge clk);
    rst = 1'b0;
    pix("post_rst_ball", 316, 236, 12'hFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
